// File: rtl/mem_responder_if.sv
// Shared memory bus between the granted requester (master) and mem_responder (slave).
// MEM_RESPONDER_PARITY_EN adds the fault_inject test input.
interface mem_responder_if #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 16
);
    logic              wr_enable;
    logic              rd_enable;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              wr_done;
    logic              rd_done;
    logic              busy;
    logic              err;
`ifdef MEM_RESPONDER_PARITY_EN
    logic              fault_inject;

    modport master (
        output wr_enable, rd_enable, addr, data_in, fault_inject,
        input  data_out, wr_done, rd_done, busy, err
    );
    modport slave (
        input  wr_enable, rd_enable, addr, data_in, fault_inject,
        output data_out, wr_done, rd_done, busy, err
    );
`else
    modport master (
        output wr_enable, rd_enable, addr, data_in,
        input  data_out, wr_done, rd_done, busy, err
    );
    modport slave (
        input  wr_enable, rd_enable, addr, data_in,
        output data_out, wr_done, rd_done, busy, err
    );
`endif
endinterface

// File: rtl/mem_responder.sv
// Single-port RAM responder: level request -> latency countdown -> done strobe -> wait for release.
// Optional MEM_RESPONDER_PARITY_EN stores an even-parity bit per word and flags mismatches on read.
module mem_responder #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned WR_LATENCY = 1,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    mem_responder_if.slave bus
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef MEM_RESPONDER_PARITY_EN
    localparam int unsigned MEM_W = DATA_W + 1;
`else
    localparam int unsigned MEM_W = DATA_W;
`endif

    typedef enum logic [1:0] {IDLE, WRITE, READ, RELEASE} state_t;

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ADDR_W-1:0] addr_q, addr_next;
    logic [DATA_W-1:0] data_q, data_next;
    logic [DATA_W-1:0] data_out_q, data_out_next;
    logic              wr_done_q, wr_done_next;
    logic              rd_done_q, rd_done_next;
    logic              err_q, err_next;
    logic              busy_q;

    logic [MEM_W-1:0]  mem [DEPTH];
    logic              mem_we;
    logic [MEM_W-1:0]  mem_wdata;
    logic [MEM_W-1:0]  mem_rword;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              parity_bad;

    assign idx       = addr_q[IDX_W-1:0];
    assign in_range  = 32'(addr_q) < DEPTH;
    assign mem_rword = mem[idx];

`ifdef MEM_RESPONDER_PARITY_EN
    // Parity bit sits above the data; fault_inject flips it at commit time.
    assign mem_wdata  = {(^data_q) ^ bus.fault_inject, data_q};
    assign parity_bad = mem_rword[DATA_W] != (^mem_rword[DATA_W-1:0]);
`else
    assign mem_wdata  = data_q;
    assign parity_bad = 1'b0;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        addr_next     = addr_q;
        data_next     = data_q;
        data_out_next = data_out_q;
        wr_done_next  = 1'b0;
        rd_done_next  = 1'b0;
        err_next      = 1'b0;
        mem_we        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.wr_enable) begin
                    state_next = WRITE;
                    cnt_next   = CNT_W'(WR_LATENCY);
                    addr_next  = bus.addr;
                    data_next  = bus.data_in;
                    err_next   = bus.rd_enable;
                end else if (bus.rd_enable) begin
                    state_next = READ;
                    cnt_next   = CNT_W'(RD_LATENCY);
                    addr_next  = bus.addr;
                end
            end
            WRITE: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    mem_we       = in_range;
                    wr_done_next = 1'b1;
                    err_next     = !in_range;
                    state_next   = RELEASE;
                end
            end
            READ: begin
                cnt_next = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    data_out_next = in_range ? mem_rword[DATA_W-1:0] : '0;
                    rd_done_next  = 1'b1;
                    err_next      = !in_range || parity_bad;
                    state_next    = RELEASE;
                end
            end
            RELEASE: begin
                // Hold here until the requester drops its level so it is not served twice.
                if (!bus.wr_enable && !bus.rd_enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            data_out_q <= '0;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            addr_q     <= addr_next;
            data_q     <= data_next;
            data_out_q <= data_out_next;
            wr_done_q  <= wr_done_next;
            rd_done_q  <= rd_done_next;
            err_q      <= err_next;
            busy_q     <= state_next != IDLE;
        end
    end

    // Array is deliberately not reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) mem[idx] <= mem_wdata;
    end

    assign bus.data_out = data_out_q;
    assign bus.wr_done  = wr_done_q;
    assign bus.rd_done  = rd_done_q;
    assign bus.err      = err_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: driver pushes expected events, negedge monitor pops and checks.
module tb_mem_responder;
    localparam int unsigned DEPTH  = 512;
    localparam int          WR_LAT = 1;
    localparam int          RD_LAT = 2;

    typedef struct {
        int          kind;   // 0 write done, 1 read done, 2 protocol err alone
        logic [15:0] data;   // expected data_out during the event
        logic        err;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    exp_t        q[$];
    logic [15:0] model[DEPTH];
    bit          corrupt[DEPTH];
    bit          written[DEPTH];
    int          wlist[$];
    logic [15:0] last_rd;
    bit          fi;

    mem_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    mem_responder #(
        .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH),
        .WR_LATENCY(WR_LAT), .RD_LATENCY(RD_LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

`ifdef MEM_RESPONDER_PARITY_EN
    assign bus.fault_inject = fi;
`endif

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Monitor: every done/err strobe must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t       e;
        logic [1:0] k;
        if (rst !== 1'b1 && (bus.wr_done || bus.rd_done || bus.err)) begin
            if (q.size() == 0) begin
                check("unexpected_strobe", 32'({bus.wr_done, bus.rd_done, bus.err}), 32'(0));
            end else begin
                e = q.pop_front();
                k = (e.kind == 0) ? 2'b10 : (e.kind == 1) ? 2'b01 : 2'b00;
                check("done_kind", 32'({bus.wr_done, bus.rd_done}), 32'(k));
                check("err", 32'(bus.err), 32'(e.err));
                check("latency_cycle", 32'(cyc), 32'(e.cyc));
                if (e.kind != 2) check("data_out", 32'(bus.data_out), 32'(e.data));
            end
        end
    end

    // One bus transaction; expectations come from the array model and the latency rules.
    task automatic do_op(input bit wr, input bit rd, input logic [15:0] a,
                         input logic [15:0] d, input int hold);
        int          acc;
        bit          inr;
        bit          seen;
        int          ix;
        logic [15:0] ed;
        @(posedge clk); #1;
        bus.wr_enable = wr;
        bus.rd_enable = rd;
        bus.addr      = a;
        bus.data_in   = d;
        acc = cyc + 1;
        inr = a < 16'(DEPTH);
        ix  = int'(a) % DEPTH;
        if (wr && rd) q.push_back('{2, 16'h0, 1'b1, acc});
        if (wr) begin
            q.push_back('{0, last_rd, !inr, acc + WR_LAT});
            if (inr) begin
                model[ix]   = d;
                corrupt[ix] = fi;
                if (!written[ix]) wlist.push_back(ix);
                written[ix] = 1'b1;
            end
        end else begin
            ed      = inr ? model[ix] : 16'h0;
            last_rd = ed;
            q.push_back('{1, ed, !inr || corrupt[ix], acc + RD_LAT});
        end
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = bus.wr_done || bus.rd_done;
        end
        if (!seen) check("done_timeout", 32'(0), 32'(1));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("busy_in_release", 32'(bus.busy), 32'(1));
        end
        @(posedge clk); #1;
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        fi = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("busy_after_release", 32'(bus.busy), 32'(0));
    endtask

    // Start a write, then reset before its commit edge; the array must keep its old word.
    task automatic reset_abort(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        bus.wr_enable = 1'b1;
        bus.addr      = a;
        bus.data_in   = d;
        @(posedge clk); #3;
        check("busy_before_rst", 32'(bus.busy), 32'(1));
        rst = 1'b1;
        #1;
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_strobes", 32'({bus.wr_done, bus.rd_done, bus.err}), 32'(0));
        check("rst_data_out", 32'(bus.data_out), 32'(0));
        bus.wr_enable = 1'b0;
        q.delete();
        last_rd = 16'h0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          wd;
        bit          w;
        bit          both;
        logic [15:0] a;
        rst = 1'b1;
        bus.wr_enable = 1'b0;
        bus.rd_enable = 1'b0;
        bus.addr      = 16'h0;
        bus.data_in   = 16'h0;
        fi            = 1'b0;
        last_rd       = 16'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'(0));
        check("reset_strobes", 32'({bus.wr_done, bus.rd_done, bus.err}), 32'(0));
        check("reset_data_out", 32'(bus.data_out), 32'(0));
        rst = 1'b0;

        do_op(1'b1, 1'b0, 16'h0005, 16'hA5C3, 0);
        do_op(1'b0, 1'b1, 16'h0005, 16'h0000, 0);
        do_op(1'b1, 1'b1, 16'h0010, 16'h1234, 0);
        do_op(1'b0, 1'b1, 16'h0010, 16'h0000, 0);
        do_op(1'b0, 1'b1, 16'h0005, 16'h0000, 10);
        do_op(1'b1, 1'b0, 16'h0000, 16'h5A5A, 0);
        do_op(1'b1, 1'b0, 16'h0200, 16'hFFFF, 0);
        do_op(1'b0, 1'b1, 16'h0000, 16'h0000, 0);
        do_op(1'b0, 1'b1, 16'h0200, 16'h0000, 0);
        do_op(1'b0, 1'b1, 16'hFFFF, 16'h0000, 1);
        do_op(1'b1, 1'b0, 16'h0007, 16'h1111, 0);
        reset_abort(16'h0007, 16'hBEEF);
        do_op(1'b0, 1'b1, 16'h0007, 16'h0000, 0);
        do_op(1'b1, 1'b0, 16'h01FF, 16'hC0DE, 0);
        do_op(1'b0, 1'b1, 16'h01FF, 16'h0000, 0);
`ifdef MEM_RESPONDER_PARITY_EN
        fi = 1'b1;
        do_op(1'b1, 1'b0, 16'h0009, 16'h00F0, 0);
        do_op(1'b0, 1'b1, 16'h0009, 16'h0000, 0);
        do_op(1'b1, 1'b0, 16'h0009, 16'h00F1, 0);
        do_op(1'b0, 1'b1, 16'h0009, 16'h0000, 0);
`endif

        for (int n = 0; n < 80; n++) begin
            w    = ($urandom_range(0, 1) == 1);
            both = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) a = 16'(32'h200 + $urandom_range(0, 32'hFDFF));
            else if (!w && wlist.size() > 0) a = 16'(wlist[$urandom_range(0, wlist.size() - 1)]);
            else a = 16'($urandom_range(0, DEPTH - 1));
            if (!w && !both && a < 16'(DEPTH) && !written[int'(a)]) w = 1'b1;
            do_op(w || both, both || !w, a, 16'($urandom), int'($urandom_range(0, 3)));
        end

        wd = 0;
        while (q.size() != 0 && wd < 50) begin
            @(negedge clk);
            wd++;
        end
        check("queue_drained", 32'(q.size()), 32'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
